// File: rtl/viterbi_pkg.sv
// viterbi_pkg: shared trellis constants, state type, predecessor rule and traceback FSM encoding
package viterbi_pkg;
  localparam int K = 4;
  localparam int M = K - 1;
  localparam int NSTATE = 1 << M;
  typedef logic [M-1:0] tb_state_t;
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DRAIN} tbu_fsm_t;
  function automatic tb_state_t tb_pred(input tb_state_t state, input logic d);
    return {d, state[M-1:1]};
  endfunction
endpackage

// File: rtl/tbu_lifo.sv
// tbu_lifo: single-bit stack that reverses one traceback block into chronological order
module tbu_lifo #(
  parameter int DEPTH = 16,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int IW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          push,
  input  logic          din,
  input  logic          pop,
  output logic          dout,
  output logic [CW-1:0] count
);
  logic [DEPTH-1:0] mem;
  logic [IW-1:0] top;
  assign top = IW'(count - CW'(1));
  assign dout = mem[top];
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      mem <= '0;
      count <= '0;
    end else if (clr) count <= '0;
    else if (push && count != CW'(DEPTH)) begin
      mem[count[IW-1:0]] <= din;
      count <= count + CW'(1);
    end else if (pop && count != '0) count <= count - CW'(1);
endmodule

// File: rtl/viterbi_tbu_p.sv
// viterbi_tbu_p: parametrised Viterbi traceback over a pipelined survivor-memory read port.
// Define VITERBI_TBU_REVERSE_EN to emit each block oldest-first through a LIFO.
module viterbi_tbu_p #(
  parameter int K = 4,
  parameter int TB_DEPTH = 16,
  parameter int DEC_LEN = 16,
  parameter int MEM_DEPTH = 64,
  localparam int M = K - 1,
  localparam int NSTATE = 1 << M,
  localparam int AW = $clog2(MEM_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              start,
  input  logic [M-1:0]      start_state,
  input  logic [AW-1:0]     start_addr,
  output logic              rd_en,
  output logic [AW-1:0]     rd_addr,
  input  logic [NSTATE-1:0] dec_word,
  output logic              d_o,
  output logic              d_valid,
  output logic              d_last,
  output logic              busy
);
  import viterbi_pkg::*;
  localparam int NSTEP = TB_DEPTH + DEC_LEN;
  localparam int CW = $clog2(NSTEP + 1);
  localparam logic [CW-1:0] FIRST_DEC = CW'(TB_DEPTH);
  localparam logic [CW-1:0] LAST_RD = CW'(NSTEP);
  tbu_fsm_t state;
  logic [CW-1:0] rd_cnt, sidx;
  logic rd_q, stp_v, accept, dec_step;
  logic [NSTATE-1:0] dw_q;
  logic [M-1:0] s;
  assign accept = state == IDLE && start && enable;
  assign dec_step = stp_v && sidx >= FIRST_DEC;
  assign busy = state != IDLE;
`ifdef VITERBI_TBU_REVERSE_EN
  localparam int LW = $clog2(DEC_LEN + 1);
  logic [LW-1:0] lifo_cnt;
  logic lifo_dout, pop;
  // popping waits until the final decode step has been pushed
  assign pop = state == DRAIN && !stp_v && lifo_cnt != '0;
  tbu_lifo #(.DEPTH(DEC_LEN)) u_lifo (
    .clk(clk), .rst(rst), .clr(!enable), .push(dec_step), .din(s[0]),
    .pop(pop), .dout(lifo_dout), .count(lifo_cnt)
  );
`else
  localparam logic [CW-1:0] LAST_STEP = CW'(NSTEP - 1);
`endif
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      rd_en <= 1'b0;
      rd_addr <= '0;
      rd_cnt <= '0;
      rd_q <= 1'b0;
      stp_v <= 1'b0;
      dw_q <= '0;
      sidx <= '0;
      s <= '0;
      d_o <= 1'b0;
      d_valid <= 1'b0;
      d_last <= 1'b0;
    end else if (!enable) begin
      state <= IDLE;
      rd_en <= 1'b0;
      rd_cnt <= '0;
      rd_q <= 1'b0;
      stp_v <= 1'b0;
      sidx <= '0;
      d_valid <= 1'b0;
      d_last <= 1'b0;
    end else begin
      rd_q <= rd_en;
      stp_v <= rd_q;
      dw_q <= dec_word;
      case (state)
        IDLE: if (start) begin
          state <= RUN;
          rd_en <= 1'b1;
          rd_addr <= start_addr;
          rd_cnt <= CW'(1);
        end
        RUN: if (rd_cnt == LAST_RD) begin
          state <= FLUSH;
          rd_en <= 1'b0;
        end else begin
          rd_cnt <= rd_cnt + CW'(1);
          rd_addr <= rd_addr - AW'(1);
        end
`ifdef VITERBI_TBU_REVERSE_EN
        FLUSH: state <= DRAIN;
        DRAIN: if (pop && lifo_cnt == LW'(1)) state <= IDLE;
`else
        FLUSH: state <= IDLE;
        default: state <= IDLE;
`endif
      endcase
      // a new start overrides the final step of the previous block
      if (stp_v) begin
        s <= {dw_q[s], s[M-1:1]};
        sidx <= sidx + CW'(1);
      end
      if (accept) begin
        s <= start_state;
        sidx <= '0;
      end
`ifdef VITERBI_TBU_REVERSE_EN
      d_valid <= pop;
      d_last <= pop && lifo_cnt == LW'(1);
      if (pop) d_o <= lifo_dout;
`else
      d_valid <= dec_step;
      d_last <= stp_v && sidx == LAST_STEP;
      if (dec_step) d_o <= s[0];
`endif
    end
endmodule

// File: tb/tb_viterbi_tbu_p.sv
// tb_viterbi_tbu_p: scoreboard bench driving convolutionally encoded survivor memories
module tb_viterbi_tbu_p;
  localparam int K = 4, TBD = 16, DL = 16, MD = 64;
  localparam int M = K - 1, NS = 1 << M, NSTEP = TBD + DL;
`ifdef VITERBI_TBU_REVERSE_EN
  localparam bit REV = 1'b1;
`else
  localparam bit REV = 1'b0;
`endif
  localparam int LAT = REV ? NSTEP + 3 : TBD + 3;
  localparam int PERIOD = REV ? NSTEP + DL + 3 : NSTEP + 2;
  logic clk = 1'b0, rst = 1'b1, enable = 1'b1, start = 1'b0;
  logic [M-1:0] start_state = '0;
  logic [5:0] start_addr = '0;
  logic rd_en, d_o, d_valid, d_last, busy;
  logic [5:0] rd_addr;
  logic [NS-1:0] dec_word;
  logic [NS-1:0] mem [MD];
  typedef struct {logic d; logic last; logic first; int t0;} exp_t;
  exp_t exp_q[$], e;
  int addr_q[$];
  int n_chk = 0, n_fail = 0, edges = 0, t_start = 0, last_edge = 0;

  viterbi_tbu_p #(.K(K), .TB_DEPTH(TBD), .DEC_LEN(DL), .MEM_DEPTH(MD)) dut (
    .clk(clk), .rst(rst), .enable(enable), .start(start), .start_state(start_state),
    .start_addr(start_addr), .rd_en(rd_en), .rd_addr(rd_addr), .dec_word(dec_word),
    .d_o(d_o), .d_valid(d_valid), .d_last(d_last), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edges <= edges + 1;
  always @(posedge clk) if (rd_en) dec_word <= mem[rd_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, req, edges);
    end
  endtask

  always @(negedge clk) begin
    if (rd_en) begin
      if (addr_q.size() == 0) chk("extra_read", 32'(rd_en), 0);
      else chk("rd_addr", 32'(rd_addr), addr_q.pop_front());
    end
    if (d_valid) begin
      if (exp_q.size() == 0) chk("extra_valid", 32'(d_valid), 0);
      else begin
        e = exp_q.pop_front();
        if (e.first) chk("latency", 32'(edges - e.t0), LAT);
        else chk("contiguous", 32'(edges - last_edge), 1);
        last_edge = edges;
        chk("d_o", 32'(d_o), 32'(e.d));
        chk("d_last", 32'(d_last), 32'(e.last));
      end
    end else if (d_last) chk("stray_last", 32'(d_last), 0);
  end

  task automatic start_job(input logic [M-1:0] st, input logic [5:0] a, input int nrd);
    start_state = st;
    start_addr = a;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    t_start = edges;
    for (int i = 0; i < nrd; i++) addr_q.push_back((int'(a) - i) & 63);
  endtask

  // b holds the decode-step bits, newest payload bit first
  task automatic push_exp(input logic [DL-1:0] b, input int n);
    for (int k = 0; k < n; k++)
      exp_q.push_back('{d: b[REV ? DL - 1 - k : k], last: k == DL - 1, first: k == 0, t0: t_start});
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      #1 n++;
    end while ((busy || exp_q.size() != 0) && n < 400);
    chk({name, "_done"}, 32'(busy || exp_q.size() != 0), 0);
    chk({name, "_reads"}, 32'(addr_q.size()), 0);
  endtask

  task automatic fill_const(input logic [NS-1:0] v);
    for (int i = 0; i < MD; i++) mem[i] = v;
  endtask

  // encode 64 random bits forward; word for time t+1 records the bit shifted out of state t
  task automatic fill_payload(input logic [5:0] a, output logic [M-1:0] fs, output logic [DL-1:0] b);
    logic [63:0] u;
    logic [M-1:0] st, nx;
    logic [NS-1:0] w;
    logic [5:0] idx;
    st = '0;
    for (int t = 0; t < 64; t++) begin
      u[t] = 1'($urandom_range(0, 1));
      nx = {st[M-2:0], u[t]};
      w = NS'($urandom);
      w[nx] = st[M-1];
      idx = a - 6'(63 - t);
      mem[idx] = w;
      st = nx;
    end
    fs = st;
    for (int j = 0; j < DL; j++) b[j] = u[63 - TBD - j];
  endtask

  initial begin
    logic [M-1:0] fs;
    logic [DL-1:0] b;
    int a, ta;
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rd_en", 32'(rd_en), 0);
    chk("rst_rd_addr", 32'(rd_addr), 0);
    chk("rst_d_o", 32'(d_o), 0);
    chk("rst_d_valid", 32'(d_valid), 0);
    chk("rst_d_last", 32'(d_last), 0);
    chk("rst_busy", 32'(busy), 0);
    rst = 1'b1;
    @(negedge clk);
    fill_const('0);
    start_job(3'b101, 6'd40, NSTEP);
    push_exp('0, DL);
    wait_idle("zeros");
    fill_const('1);
    start_job('0, 6'd2, NSTEP);
    push_exp('1, DL);
    wait_idle("ones");
    repeat (4) begin
      a = $urandom_range(0, 63);
      fill_payload(6'(a), fs, b);
      start_job(fs, 6'(a), NSTEP);
      push_exp(b, DL);
      wait_idle("payload");
    end
    fill_payload(6'd17, fs, b);
    start_job(fs, 6'd17, 11);
    repeat (10) @(posedge clk);
    #1 enable = 1'b0;
    @(posedge clk);
    #1 chk("abort_rd_en", 32'(rd_en), 0);
    chk("abort_busy", 32'(busy), 0);
    repeat (30) @(negedge clk);
    enable = 1'b1;
    chk("abort_reads", 32'(addr_q.size()), 0);
    start_job(fs, 6'd17, NSTEP);
    push_exp(b, DL);
    wait_idle("after_abort");
    a = $urandom_range(0, 63);
    fill_payload(6'(a), fs, b);
    start_job(fs, 6'(a), NSTEP);
    push_exp(b, DL);
    ta = t_start;
    repeat (5) @(posedge clk);
    #1 start_state = ~fs;
    start_addr = 6'(a) ^ 6'h15;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int n = 0; n < 400 && busy; n++) @(negedge clk);
    #1 start_job(fs, 6'(a), NSTEP);
    chk("b2b_period", 32'(t_start - ta), PERIOD);
    push_exp(b, DL);
    wait_idle("b2b");
    a = $urandom_range(0, 63);
    fill_payload(6'(a), fs, b);
    start_job(fs, 6'(a), 25);
    push_exp(b, 25 > LAT ? 25 - LAT : 0);
    repeat (25) @(posedge clk);
    #1 rst = 1'b0;
    #1 chk("mid_rst_rd_en", 32'(rd_en), 0);
    chk("mid_rst_rd_addr", 32'(rd_addr), 0);
    chk("mid_rst_d_o", 32'(d_o), 0);
    chk("mid_rst_d_valid", 32'(d_valid), 0);
    chk("mid_rst_d_last", 32'(d_last), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    chk("mid_rst_reads", 32'(addr_q.size()), 0);
    chk("mid_rst_bits", 32'(exp_q.size()), 0);
    chk("mid_rst_idle", 32'(busy), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    repeat (30000) @(posedge clk);
    $display("FAIL watchdog: still running after 30000 cycles, expected finish");
    $fatal(1);
  end
endmodule
